// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for one byte-enabled RAM port.
// Ports: CLK/RST, req0_*/req1_* valid-ready request channels with lock,
// rsp0_*/rsp1_* 1-cycle read responses, mem_* RAM port drive, mem_q data.
module mem_port_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [AWIDTH-1:0]     req0_addr,
  input  logic [DWIDTH-1:0]     req0_wdata,
  input  logic [DWIDTH/8-1:0]   req0_wbe,
  input  logic                  req0_lock,
  output logic                  rsp0_valid,
  output logic [DWIDTH-1:0]     rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [AWIDTH-1:0]     req1_addr,
  input  logic [DWIDTH-1:0]     req1_wdata,
  input  logic [DWIDTH/8-1:0]   req1_wbe,
  input  logic                  req1_lock,
  output logic                  rsp1_valid,
  output logic [DWIDTH-1:0]     rsp1_rdata,
  output logic                  mem_en,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH-1:0]     mem_d,
  output logic [DWIDTH/8-1:0]   mem_wbe,
  input  logic [DWIDTH-1:0]     mem_q
);

  logic       last_q, last_d;
  logic [1:0] lock_q, lock_d;
  logic       pend_q, pend_d;
  logic       sel_q, sel_d;

  logic gnt0, gnt1, any_gnt;

  // Grant is gated by RST so ready/mem_en drop the
  // instant reset asserts, not at the next edge.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
      if (lock_q[0] && req0_valid) begin
        gnt0 = 1'b1;
      end else if (lock_q[1] && req1_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && !req1_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid && !req0_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  // Without a grant the owner must have dropped valid,
  // so clearing lock_own there covers the release case.
  always_comb begin
    last_d = last_q;
    sel_d  = sel_q;
    pend_d = any_gnt;
    lock_d = 2'b00;
    if (any_gnt) begin
      last_d = gnt1;
      sel_d  = gnt1;
    end
    if (gnt0 && req0_lock) lock_d = 2'b01;
    if (gnt1 && req1_lock) lock_d = 2'b10;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q <= 1'b1;
      lock_q <= 2'b00;
      pend_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      lock_q <= lock_d;
      pend_q <= pend_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_en     = any_gnt;
    mem_addr   = gnt1 ? req1_addr  : req0_addr;
    mem_d      = gnt1 ? req1_wdata : req0_wdata;
    mem_wbe    = '0;
    if (gnt0) mem_wbe = req0_wbe;
    if (gnt1) mem_wbe = req1_wbe;
    rsp0_valid = pend_q & ~sel_q;
    rsp1_valid = pend_q & sel_q;
    rsp0_rdata = mem_q;
    rsp1_rdata = mem_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-enabled
// read-before-write RAM model on the shared port.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_lock = 0, req1_lock = 0;
  logic [11:0] req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0;
  logic [3:0]  req0_wbe = 0, req1_wbe = 0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_d;
  logic [3:0]  mem_wbe;
  logic [31:0] mem_q = 0;

  logic [31:0] ram [0:4095];

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.DWIDTH(32), .AWIDTH(12)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_wbe(req0_wbe), .req0_lock(req0_lock),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_wbe(req1_wbe), .req1_lock(req1_lock),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_wbe(mem_wbe), .mem_q(mem_q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_en) begin
      mem_q <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wbe[b])
          ram[mem_addr][b*8 +: 8] <= mem_d[b*8 +: 8];
    end
  end

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, v1, l0, l1;
    logic [11:0] a0, a1;
    logic [31:0] wd1;
    logic [3:0]  wbe1;
    logic        r0, r1;
    logic [11:0] ma;
    logic [3:0]  mw;
    logic        p0, p1, ck;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [15];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h1000_0000 + i;
    ram[12'h010] = 32'hA5A5_0010;
    ram[12'h020] = 32'h1122_3344;

    tv[0]  = '{1,0,0,0,'h010,'h000,0,0,1,0,'h010,0,0,0,0,0};
    tv[1]  = '{0,1,0,0,'h000,'h011,0,0,0,1,'h011,0,1,0,1,'hA5A50010};
    tv[2]  = '{1,1,0,0,'h030,'h031,0,0,1,0,'h030,0,0,1,1,'h10000011};
    tv[3]  = '{1,1,0,0,'h032,'h031,0,0,0,1,'h031,0,1,0,1,'h10000030};
    tv[4]  = '{1,1,0,0,'h032,'h033,0,0,1,0,'h032,0,0,1,1,'h10000031};
    tv[5]  = '{1,1,0,0,'h034,'h033,0,0,0,1,'h033,0,1,0,1,'h10000032};
    tv[6]  = '{0,0,0,0,'h000,'h000,0,0,0,0,'h000,0,0,1,1,'h10000033};
    tv[7]  = '{0,1,0,0,'h000,'h020,'hDEADBEEF,'h3,
               0,1,'h020,'h3,0,0,0,0};
    tv[8]  = '{0,1,0,0,'h000,'h020,0,0,0,1,'h020,0,0,1,1,'h11223344};
    tv[9]  = '{0,0,0,0,'h000,'h000,0,0,0,0,'h000,0,0,1,1,'h1122BEEF};
    tv[10] = '{1,1,1,0,'h040,'h041,0,0,1,0,'h040,0,0,0,0,0};
    tv[11] = '{1,1,1,0,'h040,'h041,0,0,1,0,'h040,0,1,0,1,'h10000040};
    tv[12] = '{1,1,1,0,'h040,'h041,0,0,1,0,'h040,0,1,0,1,'h10000040};
    tv[13] = '{0,1,0,0,'h000,'h041,0,0,0,1,'h041,0,1,0,1,'h10000040};
    tv[14] = '{0,0,0,0,'h000,'h000,0,0,0,0,'h000,0,0,1,1,'h10000041};

    // Reset holds everything low even with valid asserted.
    req0_valid = 1'b1;
    req0_addr  = 12'h010;
    @(posedge CLK); #1;
    chk("rst_rdy0", 0, {31'b0, req0_ready}, 0);
    chk("rst_en", 0, {31'b0, mem_en}, 0);
    chk("rst_rsp0", 0, {31'b0, rsp0_valid}, 0);
    chk("rst_rsp1", 0, {31'b0, rsp1_valid}, 0);
    RST = 1'b0;

    for (int i = 0; i < 15; i++) begin
      req0_valid = tv[i].v0;
      req1_valid = tv[i].v1;
      req0_lock  = tv[i].l0;
      req1_lock  = tv[i].l1;
      req0_addr  = tv[i].a0;
      req1_addr  = tv[i].a1;
      req1_wdata = tv[i].wd1;
      req1_wbe   = tv[i].wbe1;
      #1;
      chk("rdy0", i, {31'b0, req0_ready}, {31'b0, tv[i].r0});
      chk("rdy1", i, {31'b0, req1_ready}, {31'b0, tv[i].r1});
      chk("mem_en", i, {31'b0, mem_en},
          {31'b0, tv[i].r0 | tv[i].r1});
      chk("mem_wbe", i, {28'b0, mem_wbe}, {28'b0, tv[i].mw});
      if (tv[i].r0 | tv[i].r1)
        chk("mem_addr", i, {20'b0, mem_addr}, {20'b0, tv[i].ma});
      chk("rsp0_v", i, {31'b0, rsp0_valid}, {31'b0, tv[i].p0});
      chk("rsp1_v", i, {31'b0, rsp1_valid}, {31'b0, tv[i].p1});
      if (tv[i].ck && tv[i].p0)
        chk("rsp0_rd", i, rsp0_rdata, tv[i].rd);
      if (tv[i].ck && tv[i].p1)
        chk("rsp1_rd", i, rsp1_rdata, tv[i].rd);
      @(posedge CLK); #1;
    end

    // Reset while a req0 response is in flight.
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_lock  = 1'b0;
    req0_addr  = 12'h050;
    #1;
    chk("pre_rdy0", 0, {31'b0, req0_ready}, 1);
    @(posedge CLK); #1;
    chk("pend_rsp0", 0, {31'b0, rsp0_valid}, 1);
    req1_valid = 1'b1;
    req1_addr  = 12'h051;
    RST = 1'b1;
    #1;
    chk("mid_rsp0", 0, {31'b0, rsp0_valid}, 0);
    chk("mid_en", 0, {31'b0, mem_en}, 0);
    chk("mid_rdy0", 0, {31'b0, req0_ready}, 0);
    chk("mid_rdy1", 0, {31'b0, req1_ready}, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("post_rdy0", 0, {31'b0, req0_ready}, 1);
    chk("post_rdy1", 0, {31'b0, req1_ready}, 0);
    chk("post_addr", 0, {20'b0, mem_addr}, 32'h050);
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("post_rsp0", 0, {31'b0, rsp0_valid}, 1);
    chk("post_rd", 0, rsp0_rdata, 32'h1000_0050);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
